// File: rtl/lab3_counter_ctrl_pkg.sv
// Shared types for the lab-3 step counter controller: FSM state encoding and
// prescaler sizing helper.
package lab3_counter_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // DIV=1 still needs a 1-bit prescaler register to keep widths legal.
  function automatic int pre_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/lab3_counter_ctrl_if.sv
// Command/status bundle between the board buttons/switches and the counter controller.
interface lab3_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  import lab3_counter_ctrl_pkg::*;

  logic             start;
  logic             pause;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [ST_W-1:0]  state;

  modport master (
    output start, pause, dir, load, load_val,
    input  q, busy, done, state
  );

  modport slave (
    input  start, pause, dir, load, load_val,
    output q, busy, done, state
  );

endinterface

// File: rtl/lab3_step_counter.sv
// Count register for the lab-3 counter: load, single up/down step, and
// terminal-count detection with optional wrap to the opposite terminal.
module lab3_step_counter #(
  parameter int WIDTH  = 4,
  parameter int TOP    = 15,
  parameter int BOTTOM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             wrap_i,
  output logic [WIDTH-1:0] q_o,
  output logic             at_term_o
);

  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] BOT_V = WIDTH'(BOTTOM);

  logic [WIDTH-1:0] q_q, q_d;

  assign at_term_o = up_i ? (q_q == TOP_V) : (q_q == BOT_V);
  assign q_o       = q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (step_i) begin
      if (at_term_o) begin
        // Non-wrapping terminal step holds; the controller moves to DONE.
        if (wrap_i) q_d = up_i ? BOT_V : TOP_V;
      end else begin
        q_d = up_i ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= BOT_V;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/lab3_counter_ctrl.sv
// Lab-3 counter sequencer: IDLE/RUN/PAUSE/DONE FSM, step prescaler, direction
// latch and load clamp around the lab3_step_counter datapath.
module lab3_counter_ctrl
  import lab3_counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 1,
  parameter int TOP    = 15,
  parameter int BOTTOM = 0,
  parameter int WRAP   = 0
) (
  input logic               clk,
  input logic               rst,
  lab3_counter_ctrl_if.slave bus
);

  localparam int PW = pre_w(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step, at_term;
  logic [WIDTH-1:0] ld_val, q;
  int               lv;

  // Signed int compare keeps the clamp warning-free for BOTTOM=0 / TOP=max.
  always_comb begin
    lv = int'(bus.load_val);
    if (lv > TOP)         ld_val = WIDTH'(TOP);
    else if (lv < BOTTOM) ld_val = WIDTH'(BOTTOM);
    else                  ld_val = bus.load_val;
  end

  assign step = (state_q == ST_RUN) && !bus.load && !bus.pause && (pre_q == PRE_LAST);

  lab3_step_counter #(
    .WIDTH  (WIDTH),
    .TOP    (TOP),
    .BOTTOM (BOTTOM)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step),
    .up_i       (dir_q),
    .load_i     (bus.load),
    .load_val_i (ld_val),
    .wrap_i     (WRAP != 0),
    .q_o        (q),
    .at_term_o  (at_term)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pre_d   = pre_q;
    unique case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        if (!bus.load && bus.start) begin
          state_d = ST_RUN;
          dir_d   = bus.dir;
        end
      end
      ST_RUN: begin
        if (bus.load) begin
          pre_d = '0;
        end else if (bus.pause) begin
          state_d = ST_PAUSE;
        end else begin
          pre_d = step ? '0 : pre_q + PW'(1);
          if (step && at_term && WRAP == 0) state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        // Prescaler holds across a pause so resume keeps its phase.
        if (bus.load) begin
          pre_d = '0;
        end else if (!bus.pause && bus.start) begin
          state_d = ST_RUN;
          dir_d   = bus.dir;
        end
      end
      ST_DONE: begin
        pre_d = '0;
        if (bus.load || bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (WRAP != 0) ? (step && at_term) : (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q     = q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_lab3_counter_ctrl.sv
// Directed bench for lab3_counter_ctrl: default config, DIV=3/WRAP=1 config and
// TOP=12/BOTTOM=2 config, sharing one clock and reset.
module tb_lab3_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  lab3_counter_ctrl_if #(.WIDTH(4)) if0 ();
  lab3_counter_ctrl_if #(.WIDTH(4)) if1 ();
  lab3_counter_ctrl_if #(.WIDTH(4)) if2 ();

  lab3_counter_ctrl #(.WIDTH(4), .DIV(1), .TOP(15), .BOTTOM(0), .WRAP(0))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  lab3_counter_ctrl #(.WIDTH(4), .DIV(3), .TOP(15), .BOTTOM(0), .WRAP(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  lab3_counter_ctrl #(.WIDTH(4), .DIV(1), .TOP(12), .BOTTOM(2), .WRAP(0))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    {if0.start, if0.pause, if0.dir, if0.load, if0.load_val} = '0;
    {if1.start, if1.pause, if1.dir, if1.load, if1.load_val} = '0;
    {if2.start, if2.pause, if2.dir, if2.load, if2.load_val} = '0;

    // 1: reset, count up to TOP, stop in DONE
    rst = 1'b1;
    tick(); tick();
    chk("rst_q",     if0.q, 0);
    chk("rst_state", if0.state, 0);
    chk("rst_busy",  if0.busy, 0);
    chk("rst_done",  if0.done, 0);
    chk("rst_q_b2",  if2.q, 2);
    rst = 1'b0;
    if0.start = 1'b1; if0.dir = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("t1_state_run", if0.state, 1);
    chk("t1_busy",      if0.busy, 1);
    chk("t1_q0",        if0.q, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t1_q%0d", i), if0.q, i);
    end
    chk("t1_done_lo", if0.done, 0);
    tick();
    chk("t1_state_done", if0.state, 3);
    chk("t1_done_hi",    if0.done, 1);
    chk("t1_q_hold",     if0.q, 15);
    chk("t1_busy_lo",    if0.busy, 0);
    tick();
    chk("t1_q_hold2",    if0.q, 15);

    // start in DONE returns to IDLE with q held
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("t6_done_start_state", if0.state, 0);
    chk("t6_done_start_q",     if0.q, 15);
    chk("t6_done_start_done",  if0.done, 0);

    // 2: load 9, count down, pause at 6, resume, stop at BOTTOM
    if0.load = 1'b1; if0.load_val = 4'd9;
    tick();
    if0.load = 1'b0;
    chk("t2_load_q",     if0.q, 9);
    chk("t2_load_state", if0.state, 0);
    if0.start = 1'b1; if0.dir = 1'b0;
    tick();
    if0.start = 1'b0;
    chk("t2_run", if0.state, 1);
    for (int i = 8; i >= 6; i--) begin
      tick();
      chk($sformatf("t2_q%0d", i), if0.q, i);
    end
    if0.pause = 1'b1;
    tick();
    if0.pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_pause_q_%0d", i),     if0.q, 6);
      chk($sformatf("t2_pause_state_%0d", i), if0.state, 2);
      chk($sformatf("t2_pause_busy_%0d", i),  if0.busy, 0);
      if (i < 4) tick();
    end
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("t2_resume_state", if0.state, 1);
    chk("t2_resume_q",     if0.q, 6);
    for (int i = 5; i >= 0; i--) begin
      tick();
      chk($sformatf("t2_dn_q%0d", i), if0.q, i);
    end
    tick();
    chk("t2_done_state", if0.state, 3);
    chk("t2_done",       if0.done, 1);
    chk("t2_done_q",     if0.q, 0);

    // 3: DIV=3 WRAP=1, load 14, count up through wrap
    if1.load = 1'b1; if1.load_val = 4'd14;
    tick();
    if1.load = 1'b0;
    chk("t3_load_q", if1.q, 14);
    if1.start = 1'b1; if1.dir = 1'b1;
    tick();
    if1.start = 1'b0;
    chk("t3_run", if1.state, 1);
    tick(); tick();
    chk("t3_q14_hold", if1.q, 14);
    tick();
    chk("t3_q15", if1.q, 15);
    tick(); tick();
    chk("t3_q15_hold", if1.q, 15);
    chk("t3_done_pre", if1.done, 0);
    tick();
    chk("t3_wrap_q",     if1.q, 0);
    chk("t3_wrap_done",  if1.done, 1);
    chk("t3_wrap_state", if1.state, 1);
    tick();
    chk("t3_done_pulse_end", if1.done, 0);
    chk("t3_state_still_run", if1.state, 1);

    // 4: load+pause+start together in RUN, DIV=3
    if1.load = 1'b1; if1.load_val = 4'd3; if1.pause = 1'b1; if1.start = 1'b1;
    tick();
    {if1.load, if1.pause, if1.start} = '0;
    chk("t4_q3",    if1.q, 3);
    chk("t4_state", if1.state, 1);
    tick(); tick();
    chk("t4_q3_hold", if1.q, 3);
    tick();
    chk("t4_q4", if1.q, 4);

    // 5: clamp at TOP=12 / BOTTOM=2, then count down to BOTTOM
    if2.load = 1'b1; if2.load_val = 4'd15;
    tick();
    chk("t5_clamp_top", if2.q, 12);
    if2.load_val = 4'd0;
    tick();
    chk("t5_clamp_bot", if2.q, 2);
    if2.load_val = 4'd7;
    tick();
    if2.load = 1'b0;
    chk("t5_pass", if2.q, 7);
    if2.start = 1'b1; if2.dir = 1'b0;
    tick();
    if2.start = 1'b0;
    for (int i = 6; i >= 2; i--) begin
      tick();
      chk($sformatf("t5_q%0d", i), if2.q, i);
    end
    tick();
    chk("t5_done_state", if2.state, 3);
    chk("t5_done_q",     if2.q, 2);

    // 6: reset mid-RUN at q=7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if0.start = 1'b1; if0.dir = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t6_q7", if0.q, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_q",     if0.q, 0);
    chk("t6_rst_state", if0.state, 0);
    chk("t6_rst_busy",  if0.busy, 0);
    chk("t6_rst_done",  if0.done, 0);
    tick();
    chk("t6_no_step", if0.q, 0);

    // 4 again with DIV=1: step resumes one cycle after the load
    if0.start = 1'b1; if0.dir = 1'b1;
    tick();
    if0.start = 1'b0;
    tick(); tick();
    chk("t4b_q2", if0.q, 2);
    if0.load = 1'b1; if0.load_val = 4'd3; if0.pause = 1'b1; if0.start = 1'b1;
    tick();
    {if0.load, if0.pause, if0.start} = '0;
    chk("t4b_q3",    if0.q, 3);
    chk("t4b_state", if0.state, 1);
    tick();
    chk("t4b_q4", if0.q, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
